// File: rtl/uart_boot_pkg.sv
// rtl/uart_boot_pkg.sv - shared state encoding and error codes for the UART boot loader
package uart_boot_pkg;

  typedef enum logic [3:0] {
    IDLE,
    REQ_LEN,
    WAIT_LEN,
    REQ_WORD,
    WAIT_WORD,
    WRITE,
    REQ_SUM,
    WAIT_SUM,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_SUM  = 2'd2;

endpackage

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - loads a length-prefixed UART word stream into instruction memory, then releases the core
// Optional trailing checksum word: UART_BOOT_LOADER_CHECKSUM_EN
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter int          BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = (32'd1 << ADDR_W) - BASE_ADDR
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              rx_req,
  input  logic              rx_valid,
  input  logic [31:0]       rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic              cpu_run
);

  state_t            state;
  logic [31:0]       n;
  logic [31:0]       count;
  logic [ADDR_W-1:0] addr;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  logic [31:0]       sum;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      n         <= '0;
      count     <= '0;
      addr      <= ADDR_W'(BASE_ADDR);
      rx_req    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= ERR_NONE;
      cpu_run   <= 1'b0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= REQ_LEN;
            rx_req <= 1'b1;
            busy   <= 1'b1;
          end
        end
        REQ_LEN: begin
          rx_req <= 1'b0;
          state  <= WAIT_LEN;
        end
        WAIT_LEN: begin
          if (rx_valid) begin
            n <= rx_data;
            if (rx_data == 32'd0) begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
              state  <= REQ_SUM;
              rx_req <= 1'b1;
`else
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              cpu_run <= 1'b1;
`endif
            end else if (rx_data > MAX_WORDS) begin
              state <= ERR;
              busy  <= 1'b0;
              err   <= ERR_LEN;
            end else begin
              state  <= REQ_WORD;
              rx_req <= 1'b1;
            end
          end
        end
        REQ_WORD: begin
          rx_req <= 1'b0;
          state  <= WAIT_WORD;
        end
        WAIT_WORD: begin
          // mem_addr/mem_wdata are loaded here so they stay put after the write
          if (rx_valid) begin
            mem_wdata <= rx_data;
            mem_addr  <= addr;
            mem_we    <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          mem_we <= 1'b0;
          addr   <= addr + 1'b1;
          count  <= count + 32'd1;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
          sum    <= sum + mem_wdata;
`endif
          if (count + 32'd1 == n) begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            state  <= REQ_SUM;
            rx_req <= 1'b1;
`else
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            cpu_run <= 1'b1;
`endif
          end else begin
            state  <= REQ_WORD;
            rx_req <= 1'b1;
          end
        end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        REQ_SUM: begin
          rx_req <= 1'b0;
          state  <= WAIT_SUM;
        end
        WAIT_SUM: begin
          if (rx_valid) begin
            busy <= 1'b0;
            if (rx_data == sum) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              state <= ERR;
              err   <= ERR_SUM;
            end
          end
        end
`endif
        DONE: begin
          state <= DONE;
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - directed self-checking bench for uart_boot_loader
module tb_uart_boot_loader;
  import uart_boot_pkg::*;

  localparam int ADDR_W = 14;

  logic              clk;
  logic              rstn;
  logic              start;
  logic              rx_req;
  logic              rx_valid;
  logic [31:0]       rx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic [1:0]        err;
  logic              cpu_run;

  int tests  = 0;
  int failed = 0;

  int          req_cnt = 0;
  int          we_cnt  = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];

  uart_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .rx_req   (rx_req),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_run  (cpu_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn) begin
      if (rx_req) req_cnt++;
      if (mem_we && we_cnt < 64) begin
        wr_addr[we_cnt] = 32'(mem_addr);
        wr_data[we_cnt] = mem_wdata;
        we_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for the request pulse, then answers in the following WAIT cycle.
  task automatic send_word(input logic [31:0] d);
    int i;
    for (i = 0; i < 50 && !rx_req; i++) tick();
    if (!rx_req) check("rx_req_timeout", 32'd0, 32'd1);
    tick();
    rx_valid = 1'b1;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
    rx_data  = 32'h0;
  endtask

  task automatic send_sum(input logic [31:0] s);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    tick();
    send_word(s);
`else
    if (s == 32'hFFFF_FFFF) tick();
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_req"}, 32'(rx_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    int r0, w0;
    rstn     = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 32'h0;

    // Reset values
    do_reset();
    check_idle_outputs("rst");

    // Three-word load
    r0 = req_cnt; w0 = we_cnt;
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    send_word(32'd3);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    send_sum(32'h6666_6666);
    tick();
    tick();
    check("t1_we_count", 32'(we_cnt - w0), 32'd3);
    check("t1_addr0", wr_addr[w0], 32'd0);
    check("t1_data0", wr_data[w0], 32'h1111_1111);
    check("t1_addr1", wr_addr[w0+1], 32'd1);
    check("t1_data1", wr_data[w0+1], 32'h2222_2222);
    check("t1_addr2", wr_addr[w0+2], 32'd2);
    check("t1_data2", wr_data[w0+2], 32'h3333_3333);
    check("t1_done", 32'(done), 32'd1);
    check("t1_cpu_run", 32'(cpu_run), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_mem_addr_hold", 32'(mem_addr), 32'd2);
    check("t1_mem_wdata_hold", mem_wdata, 32'h3333_3333);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    check("t1_req_count", 32'(req_cnt - r0), 32'd5);
`else
    check("t1_req_count", 32'(req_cnt - r0), 32'd4);
`endif

    // Zero-length load
    do_reset();
    w0 = we_cnt;
    pulse_start();
    send_word(32'd0);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    check("t2_busy_sum", 32'(busy), 32'd1);
    send_sum(32'd0);
`endif
    check("t2_done", 32'(done), 32'd1);
    check("t2_cpu_run", 32'(cpu_run), 32'd1);
    check("t2_we_count", 32'(we_cnt - w0), 32'd0);

    // Length one beyond the limit
    do_reset();
    r0 = req_cnt; w0 = we_cnt;
    pulse_start();
    send_word(32'd16385);
    check("t3_err", 32'(err), 32'(ERR_LEN));
    check("t3_done", 32'(done), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    pulse_start();
    tick();
    tick();
    check("t3_state_after_start", 32'(dut.state), 32'(ERR));
    check("t3_req_count", 32'(req_cnt - r0), 32'd1);
    check("t3_we_count", 32'(we_cnt - w0), 32'd0);

    // Reset in the middle of a load, then a fresh single-word load
    do_reset();
    pulse_start();
    send_word(32'd3);
    send_word(32'hA5A5_0001);
    send_word(32'hA5A5_0002);
    rstn = 1'b0;
    tick();
    check_idle_outputs("t4_midrst");
    rstn = 1'b1;
    w0 = we_cnt;
    pulse_start();
    send_word(32'd1);
    send_word(32'hABCD_0001);
    send_sum(32'hABCD_0001);
    tick();
    tick();
    check("t4_we_count", 32'(we_cnt - w0), 32'd1);
    check("t4_addr", wr_addr[w0], 32'd0);
    check("t4_data", wr_data[w0], 32'hABCD_0001);
    check("t4_done", 32'(done), 32'd1);

    // Spurious rx_valid in IDLE and REQ_WORD, start while busy
    do_reset();
    w0 = we_cnt;
    rx_valid = 1'b1;
    rx_data  = 32'h0000_0005;
    tick();
    rx_valid = 1'b0;
    check("t5_idle_state", 32'(dut.state), 32'(IDLE));
    check("t5_idle_busy", 32'(busy), 32'd0);
    pulse_start();
    send_word(32'd2);
    send_word(32'h0000_0A0A);
    for (int i = 0; i < 10 && !rx_req; i++) tick();
    check("t5_in_req_word", 32'(dut.state), 32'(REQ_WORD));
    rx_valid = 1'b1;
    rx_data  = 32'hDEAD_BEEF;
    tick();
    rx_valid = 1'b0;
    check("t5_wait_word", 32'(dut.state), 32'(WAIT_WORD));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_start_busy_state", 32'(dut.state), 32'(WAIT_WORD));
    check("t5_start_busy_req", 32'(rx_req), 32'd0);
    rx_valid = 1'b1;
    rx_data  = 32'h0000_0B0B;
    tick();
    rx_valid = 1'b0;
    send_sum(32'h0000_1515);
    tick();
    tick();
    check("t5_we_count", 32'(we_cnt - w0), 32'd2);
    check("t5_data0", wr_data[w0], 32'h0000_0A0A);
    check("t5_data1", wr_data[w0+1], 32'h0000_0B0B);
    check("t5_addr1", wr_addr[w0+1], 32'd1);
    check("t5_done", 32'(done), 32'd1);

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    do_reset();
    pulse_start();
    send_word(32'd2);
    send_word(32'd5);
    send_word(32'd7);
    send_sum(32'd12);
    check("t6_done", 32'(done), 32'd1);
    check("t6_err", 32'(err), 32'(ERR_NONE));
    do_reset();
    pulse_start();
    send_word(32'd2);
    send_word(32'd5);
    send_word(32'd7);
    send_sum(32'd13);
    check("t6_bad_err", 32'(err), 32'(ERR_SUM));
    check("t6_bad_done", 32'(done), 32'd0);
    check("t6_bad_cpu_run", 32'(cpu_run), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Controller that sequences the 32-bit UART receive word stream into instruction memory at boot.
- Protocol: a header word N gives the payload length. N payload words follow. They are written to consecutive addresses from BASE_ADDR. Then cpu_run is released.
- Position: between the UART receive block (word-level request/valid handshake) and the instruction-memory write port.
- Holds the core in reset until the load completes.

Parameters:
- ADDR_W, 14, word-address width of instruction memory.
- BASE_ADDR, 0, first word address written.
- MAX_WORDS, 2**ADDR_W - BASE_ADDR, largest accepted N.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle pulse; begins a load.
- rx_req  output  1  one-cycle pulse requesting the next received word.
- rx_valid  input  1  one-cycle pulse; rx_data valid.
- rx_data  input  32  received word, little-endian byte assembly.
- mem_we  output  1  instruction-memory write enable.
- mem_addr  output  ADDR_W  write word address.
- mem_wdata  output  32  write data.
- busy  output  1  load in progress.
- done  output  1  sticky; load completed successfully.
- err  output  2  sticky error code: 0 none, 1 length, 2 checksum.
- cpu_run  output  1  core reset release; equals done.

Behaviour:
- Reset: all outputs 0; state IDLE; word counter 0; address BASE_ADDR.
- Reset mid-load: same values on the next edge. Any write in flight is dropped; mem_we is 0 on the cycle after reset is sampled.
- States:
  - IDLE: on start -> REQ_LEN.
  - REQ_LEN: rx_req=1 for exactly one cycle -> WAIT_LEN.
  - WAIT_LEN: on rx_valid, latch N = rx_data.
    - N==0 -> DONE.
    - N>MAX_WORDS -> ERR, err=1.
    - Otherwise -> REQ_WORD.
  - REQ_WORD: rx_req=1 for one cycle -> WAIT_WORD.
  - WAIT_WORD: on rx_valid at cycle t -> WRITE.
  - WRITE: at cycle t+1, mem_we=1 with mem_wdata=rx_data latched at t and the current address. Increment address and counter.
    - Counter reaches N -> DONE (or REQ_SUM with the option).
    - Otherwise -> REQ_WORD at t+2.
  - DONE: done=1 and cpu_run=1; terminal until reset.
  - ERR: terminal until reset; done stays 0.
- busy=1 in every state except IDLE, DONE and ERR.
- mem_we is high only in WRITE. mem_addr and mem_wdata hold their last values otherwise.
- Exactly one rx_req is issued per expected word. rx_req is never asserted while waiting.
- rx_valid outside a WAIT state is ignored; no state change.
- start outside IDLE is ignored, including a start coincident with rx_valid.
- No timeout: WAIT states wait indefinitely.
- Counter width: 32 bits, compared against the full 32-bit N. Address arithmetic is ADDR_W bits; wrap cannot occur because of the MAX_WORDS check.
- Peak throughput: one word per 3 cycles plus UART latency.

Optional Feature:
- Macro: UART_BOOT_LOADER_CHECKSUM_EN.
- With the macro:
  - A running sum, mod 2^32, of payload words is accumulated in WRITE.
  - After the last write: REQ_SUM (one rx_req) -> WAIT_SUM.
  - On rx_valid: equal to sum -> DONE; otherwise -> ERR with err=2.
  - N==0 still reads a checksum word and expects 0.
- Without the macro: no checksum word is requested, err never equals 2, and the accumulator is absent.

Decomposition:
- Package uart_boot_pkg:
  - state enum: IDLE, REQ_LEN, WAIT_LEN, REQ_WORD, WAIT_WORD, WRITE, REQ_SUM, WAIT_SUM, DONE, ERR.
  - err code constants: ERR_NONE=0, ERR_LEN=1, ERR_SUM=2.
- Single module; no sub-module. The checksum accumulator stays inline under the macro.

Test Plan:
- start, then N=3 and words 0x11111111, 0x22222222, 0x33333333:
  - mem_we pulses at addresses 0, 1, 2 with those data.
  - done=1, cpu_run=1, err=0.
  - Exactly 4 rx_req pulses.
- N=0 (no checksum): done the cycle after WAIT_LEN's rx_valid, zero mem_we pulses.
- N=MAX_WORDS+1: err=1, done=0, no mem_we; later start is ignored.
- rstn low for 1 cycle after the 2nd payload word:
  - All outputs 0 and state IDLE.
  - A fresh start with N=1 writes address 0.
- Spurious rx_valid while in IDLE and in REQ_WORD: no state change, no write. Also check that start during busy is ignored.
- With the macro: N=2, words 5 and 7, checksum 12 -> done. Repeat with checksum 13 -> err=2, done=0.
